// File: rtl/cx_switch_pt_if.sv
// Ibex-side CX bundle: request payload/handshake and response handshake.
// master = Ibex side, slave = cx_switch_pt.
interface cx_switch_pt_if #(
    parameter int CXU_ID_W = 2,
    parameter int XLEN     = 32
) ();
    logic                cx_req_valid;
    logic                cx_req_ready;
    logic [CXU_ID_W-1:0] cx_cxu_id;
    logic [1:0]          cx_state_id;
    logic [XLEN-1:0]     cx_req_data0;
    logic [XLEN-1:0]     cx_req_data1;
    logic                cx_resp_valid;
    logic                cx_resp_ready;
    logic                cx_resp_state;
    logic [3:0]          cx_resp_status;
    logic [XLEN-1:0]     cx_resp_data;

    modport master (
        output cx_req_valid, cx_cxu_id, cx_state_id,
        output cx_req_data0, cx_req_data1, cx_resp_ready,
        input  cx_req_ready, cx_resp_valid, cx_resp_state,
        input  cx_resp_status, cx_resp_data
    );

    modport slave (
        input  cx_req_valid, cx_cxu_id, cx_state_id,
        input  cx_req_data0, cx_req_data1, cx_resp_ready,
        output cx_req_ready, cx_resp_valid, cx_resp_state,
        output cx_resp_status, cx_resp_data
    );
endinterface

// File: rtl/cx_switch_pt.sv
// CX request router: one outstanding request steered one-hot to a CXU.
// Ports: clk/rst, cx (Ibex side, slave), cxu_* per-CXU buses, broadcasts.
module cx_switch_pt #(
    parameter int N_CXU          = 4,
    parameter int CXU_ID_W       = 2,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    cx_switch_pt_if.slave         cx,
    input  logic [XLEN*N_CXU-1:0] cxu_responses,
    input  logic [N_CXU-1:0]      cxu_replying,
    input  logic [4*N_CXU-1:0]    cxu_statuses,
    output logic [N_CXU-1:0]      cxu_requesting,
    output logic [XLEN-1:0]       cxu_data0_o,
    output logic [XLEN-1:0]       cxu_data1_o,
    output logic [1:0]            cx_state_id_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CXU_ID_W:0] N_LIM = (CXU_ID_W+1)'(N_CXU);

    localparam logic [3:0] ST_BAD_ID  = 4'hE;
    localparam logic [3:0] ST_TIMEOUT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [CXU_ID_W-1:0] id_q, id_d;
    logic [1:0]          sid_q, sid_d;
    logic [XLEN-1:0]     d0_q, d0_d;
    logic [XLEN-1:0]     d1_q, d1_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [3:0]          rstat_q, rstat_d;

    logic                in_req, in_resp, idle_like;
    logic                hit, tmo, id_ok;
    logic [N_CXU-1:0]    onehot;
    logic [XLEN-1:0]     sel_data;
    logic [3:0]          sel_stat;

    // The encoding 2'b11 is never entered; it behaves exactly like IDLE.
    assign in_req    = (state_q == REQ);
    assign in_resp   = (state_q == RESP);
    assign idle_like = !in_req && !in_resp;

    assign id_ok = {1'b0, cx.cx_cxu_id} < N_LIM;
    assign tmo   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Decode from the latched id only, so stray strobes from other
    // CXUs and ids beyond N_CXU never select anything.
    always_comb begin
        onehot   = '0;
        hit      = 1'b0;
        sel_data = '0;
        sel_stat = '0;
        for (int i = 0; i < N_CXU; i++) begin
            if (id_q == CXU_ID_W'(i)) begin
                onehot[i] = 1'b1;
                hit       = cxu_replying[i];
                sel_data  = cxu_responses[i*XLEN +: XLEN];
                sel_stat  = cxu_statuses[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        sid_d   = sid_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        cnt_d   = '0;
        rdata_d = rdata_q;
        rstat_d = rstat_q;
        if (idle_like) begin
            state_d = IDLE;
            if (cx.cx_req_valid) begin
                id_d  = cx.cx_cxu_id;
                sid_d = cx.cx_state_id;
                d0_d  = cx.cx_req_data0;
                d1_d  = cx.cx_req_data1;
                if (id_ok) begin
                    state_d = REQ;
                end else begin
                    state_d = RESP;
                    rdata_d = '0;
                    rstat_d = ST_BAD_ID;
                end
            end
        end else if (in_req) begin
            cnt_d = cnt_q + 1'b1;
            if (hit) begin
                state_d = RESP;
                rdata_d = sel_data;
                rstat_d = sel_stat;
            end else if (tmo) begin
                state_d = RESP;
                rdata_d = '0;
                rstat_d = ST_TIMEOUT;
            end
        end else begin
            if (cx.cx_resp_ready) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            sid_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rstat_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            sid_q   <= sid_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rstat_q <= rstat_d;
        end
    end

    assign cx.cx_req_ready   = idle_like;
    assign cx.cx_resp_valid  = in_resp;
    assign cx.cx_resp_state  = 1'b0;
    assign cx.cx_resp_data   = in_resp ? rdata_q : '0;
    assign cx.cx_resp_status = in_resp ? rstat_q : 4'h0;

    assign cxu_requesting = in_req ? onehot : '0;
    assign cxu_data0_o    = d0_q;
    assign cxu_data1_o    = d1_q;
    assign cx_state_id_o  = sid_q;
endmodule

// File: tb/tb_cx_switch_pt.sv
// Directed bench for cx_switch_pt (N_CXU=3, TIMEOUT_CYCLES=4).
// Vector table of transactions plus hold and reset-abort sequences.
module tb_cx_switch_pt;
    localparam int N   = 3;
    localparam int W   = 2;
    localparam int XL  = 32;
    localparam int TMO = 4;
    localparam int NEVER = 99;

    logic          clk = 1'b0;
    logic          rst;
    logic [XL*N-1:0] cxu_responses;
    logic [N-1:0]    cxu_replying;
    logic [4*N-1:0]  cxu_statuses;
    logic [N-1:0]    cxu_requesting;
    logic [XL-1:0]   cxu_data0_o;
    logic [XL-1:0]   cxu_data1_o;
    logic [1:0]      cx_state_id_o;

    int n_chk  = 0;
    int n_fail = 0;

    cx_switch_pt_if #(.CXU_ID_W(W), .XLEN(XL)) cx ();

    cx_switch_pt #(
        .N_CXU(N), .CXU_ID_W(W), .XLEN(XL), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cx             (cx.slave),
        .cxu_responses  (cxu_responses),
        .cxu_replying   (cxu_replying),
        .cxu_statuses   (cxu_statuses),
        .cxu_requesting (cxu_requesting),
        .cxu_data0_o    (cxu_data0_o),
        .cxu_data1_o    (cxu_data1_o),
        .cx_state_id_o  (cx_state_id_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [1:0]  sid;
        logic [31:0] d0;
        logic [31:0] d1;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  rstat;
        logic [2:0]  exp_req;
        int          exp_cycles;
        logic [3:0]  exp_stat;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Target lane carries the vector's reply; the others carry junk.
    task automatic set_lanes(input logic [1:0] id, input logic [31:0] rd,
                             input logic [3:0] rs, input logic [31:0] junk);
        for (int i = 0; i < N; i++) begin
            if (int'(id) == i) begin
                cxu_responses[i*XL +: XL] = rd;
                cxu_statuses[i*4 +: 4]    = rs;
            end else begin
                cxu_responses[i*XL +: XL] = junk ^ 32'(i);
                cxu_statuses[i*4 +: 4]    = 4'hC;
            end
        end
    endtask

    task automatic issue(input logic [1:0] id, input logic [1:0] sid,
                         input logic [31:0] d0, input logic [31:0] d1);
        cx.cx_req_valid = 1'b1;
        cx.cx_cxu_id    = id;
        cx.cx_state_id  = sid;
        cx.cx_req_data0 = d0;
        cx.cx_req_data1 = d1;
        step();
        cx.cx_req_valid = 1'b0;
    endtask

    task automatic do_txn(input int k, input vec_t v);
        logic [2:0] tgt;
        int cyc;
        string p;
        p = $sformatf("v%0d", k);
        tgt = (v.id < 2'(N)) ? (3'b001 << v.id) : 3'b000;
        chk({p, " req_ready_idle"}, cx.cx_req_ready, 1'b1);
        set_lanes(v.id, v.rdata, v.rstat, 32'hBAD0_0000);
        issue(v.id, v.sid, v.d0, v.d1);
        cyc = 0;
        for (int c = 0; c < 20; c++) begin
            if (cx.cx_resp_valid) break;
            chk({p, " requesting"}, cxu_requesting, v.exp_req);
            if (cxu_requesting != 0) cyc++;
            cxu_replying = (c == v.delay) ? 3'b111 : ~tgt;
            step();
        end
        cxu_replying = '0;
        chk({p, " req_cycles"}, cyc, v.exp_cycles);
        chk({p, " resp_valid"}, cx.cx_resp_valid, 1'b1);
        chk({p, " resp_status"}, cx.cx_resp_status, v.exp_stat);
        chk({p, " resp_data"}, cx.cx_resp_data, v.exp_data);
        chk({p, " req_ready_resp"}, cx.cx_req_ready, 1'b0);
        chk({p, " data0_o"}, cxu_data0_o, v.d0);
        chk({p, " data1_o"}, cxu_data1_o, v.d1);
        chk({p, " state_id_o"}, cx_state_id_o, v.sid);
        cx.cx_resp_ready = 1'b1;
        step();
        cx.cx_resp_ready = 1'b0;
        chk({p, " resp_valid_done"}, cx.cx_resp_valid, 1'b0);
        chk({p, " resp_data_idle"}, cx.cx_resp_data, 32'h0);
        chk({p, " req_ready_done"}, cx.cx_req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            id     sid    d0            d1            dly    rdata         rs     req     cyc  st     data
        vecs[0] = '{2'd1, 2'd1, 32'h11,       32'h22,       0,     32'h0000CAFE, 4'h3, 3'b010, 1,   4'h3, 32'h0000CAFE};
        vecs[1] = '{2'd3, 2'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 0,     32'h77777777, 4'h1, 3'b000, 0,   4'hE, 32'h0};
        vecs[2] = '{2'd0, 2'd3, 32'h1,        32'h2,        NEVER, 32'h33333333, 4'h4, 3'b001, TMO, 4'hF, 32'h0};
        vecs[3] = '{2'd2, 2'd0, 32'h3,        32'h4,        TMO-1, 32'h12345678, 4'h5, 3'b100, TMO, 4'h5, 32'h12345678};
        vecs[4] = '{2'd2, 2'd1, 32'hFFFFFFFF, 32'h0,        1,     32'hDEADBEEF, 4'hA, 3'b100, 2,   4'hA, 32'hDEADBEEF};
        vecs[5] = '{2'd1, 2'd2, 32'h80000000, 32'h7FFFFFFF, 2,     32'h0,        4'h7, 3'b010, 3,   4'h7, 32'h0};

        rst = 1'b1;
        cx.cx_req_valid  = 1'b0;
        cx.cx_cxu_id     = '0;
        cx.cx_state_id   = '0;
        cx.cx_req_data0  = '0;
        cx.cx_req_data1  = '0;
        cx.cx_resp_ready = 1'b0;
        cxu_replying  = '0;
        cxu_responses = '0;
        cxu_statuses  = '0;
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst req_ready", cx.cx_req_ready, 1'b1);
        chk("rst resp_valid", cx.cx_resp_valid, 1'b0);
        chk("rst requesting", cxu_requesting, 3'b000);
        chk("rst resp_data", cx.cx_resp_data, 32'h0);
        chk("rst resp_status", cx.cx_resp_status, 4'h0);
        chk("rst resp_state", cx.cx_resp_state, 1'b0);
        chk("rst data0_o", cxu_data0_o, 32'h0);
        chk("rst data1_o", cxu_data1_o, 32'h0);
        chk("rst state_id_o", cx_state_id_o, 2'd0);

        foreach (vecs[k]) do_txn(k, vecs[k]);

        // Held response: stable while every CXU toggles its strobe.
        set_lanes(2'd0, 32'h000055AA, 4'h2, 32'hBAD1_0000);
        issue(2'd0, 2'd1, 32'h99, 32'h98);
        cxu_replying = 3'b001;
        step();
        cxu_replying = '0;
        for (int c = 0; c < 5; c++) begin
            set_lanes(2'd0, 32'h1000 + 32'(c), 4'(c), 32'hBAD2_0000);
            cxu_replying = (c % 2 == 0) ? 3'b111 : 3'b010;
            cx.cx_req_valid = 1'b1;
            chk($sformatf("hold%0d resp_valid", c), cx.cx_resp_valid, 1'b1);
            chk($sformatf("hold%0d resp_data", c), cx.cx_resp_data, 32'h000055AA);
            chk($sformatf("hold%0d resp_status", c), cx.cx_resp_status, 4'h2);
            chk($sformatf("hold%0d req_ready", c), cx.cx_req_ready, 1'b0);
            chk($sformatf("hold%0d requesting", c), cxu_requesting, 3'b000);
            step();
        end
        cx.cx_req_valid = 1'b0;
        cxu_replying = '0;
        cx.cx_resp_ready = 1'b1;
        step();
        cx.cx_resp_ready = 1'b0;
        chk("hold released", cx.cx_resp_valid, 1'b0);
        chk("hold req_ready", cx.cx_req_ready, 1'b1);

        // Reset while waiting on CXU1: the reply must never surface.
        set_lanes(2'd1, 32'h0BADF00D, 4'h6, 32'hBAD3_0000);
        issue(2'd1, 2'd0, 32'h5, 32'h6);
        chk("abort requesting", cxu_requesting, 3'b010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort requesting_drop", cxu_requesting, 3'b000);
        chk("abort req_ready", cx.cx_req_ready, 1'b1);
        chk("abort resp_valid", cx.cx_resp_valid, 1'b0);
        cxu_replying = 3'b010;
        step();
        cxu_replying = '0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("abort%0d no_resp", c), cx.cx_resp_valid, 1'b0);
            chk($sformatf("abort%0d no_req", c), cxu_requesting, 3'b000);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
